// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: latches a word read/write request, waits
// WAIT_CYCLES, performs the access against a range-checked SRAM model, then pulses ready.
module data_mem_responder #(
    parameter int REGISTER_LEN = 32,
    parameter int DEPTH        = 64,
    parameter int BASE_ADDR    = 1024,
    parameter int WAIT_CYCLES  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mem_read,
    input  logic                    mem_write,
    input  logic [REGISTER_LEN-1:0] addr,
    input  logic [REGISTER_LEN-1:0] write_data,
    output logic [REGISTER_LEN-1:0] read_data,
    output logic                    ready,
    output logic                    addr_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [REGISTER_LEN-1:0] BASE = REGISTER_LEN'(BASE_ADDR);
    localparam logic [REGISTER_LEN-1:0] SPAN = REGISTER_LEN'(4 * DEPTH);
    localparam logic [3:0]              LAST = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t                  state;
    logic [3:0]              cnt;
    logic                    op_rd;
    logic                    op_wr;
    logic [REGISTER_LEN-1:0] addr_q;
    logic [REGISTER_LEN-1:0] wdata_q;
    logic [REGISTER_LEN-1:0] mem [DEPTH];

    logic                    req;
    logic [REGISTER_LEN-1:0] offset;
    logic                    in_range;
    logic [IDX_W-1:0]        idx;
    logic                    finish;

    assign req    = mem_read | mem_write;
    assign ready  = (state == DONE) || ((state == IDLE) && !req);

    // Offset wraps when addr_q < BASE; the explicit lower-bound compare covers that.
    assign offset   = addr_q - BASE;
    assign in_range = (addr_q >= BASE) && (offset < SPAN) && (addr_q[1:0] == 2'b00);
    assign idx      = offset[IDX_W+1:2];
    assign finish   = (state == WAIT) && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (finish && op_wr && in_range)
            mem[idx] <= wdata_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            op_rd     <= 1'b0;
            op_wr     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            read_data <= '0;
            addr_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    addr_err <= 1'b0;
                    if (req) begin
                        op_rd   <= mem_read;
                        op_wr   <= mem_write;
                        addr_q  <= addr;
                        wdata_q <= write_data;
                        cnt     <= 4'd1;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == LAST) begin
                        state    <= DONE;
                        addr_err <= !in_range || (op_rd && op_wr);
                        if (!op_wr)
                            read_data <= in_range ? mem[idx] : '0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    cnt      <= '0;
                    addr_err <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder at WAIT_CYCLES 4, 1 and 15 with a
// scoreboard of expected load data / addr_err popped at each DONE cycle.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        mr  [3];
    logic        mw  [3];
    logic        rdy [3];
    logic        err [3];
    logic [31:0] ad  [3];
    logic [31:0] wd  [3];
    logic [31:0] rdd [3];

    int checks   = 0;
    int failures = 0;
    int wc [3]   = '{4, 1, 15};

    typedef struct {
        string       tag;
        logic [31:0] rd;
        logic        err;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] model [longint];
    logic [31:0] last_rd [3];

    always #5 clk = ~clk;

    data_mem_responder u_wc4 (
        .clk(clk), .rst(rst), .mem_read(mr[0]), .mem_write(mw[0]), .addr(ad[0]),
        .write_data(wd[0]), .read_data(rdd[0]), .ready(rdy[0]), .addr_err(err[0])
    );

    data_mem_responder #(.WAIT_CYCLES(1)) u_wc1 (
        .clk(clk), .rst(rst), .mem_read(mr[1]), .mem_write(mw[1]), .addr(ad[1]),
        .write_data(wd[1]), .read_data(rdd[1]), .ready(rdy[1]), .addr_err(err[1])
    );

    data_mem_responder #(.WAIT_CYCLES(15)) u_wc15 (
        .clk(clk), .rst(rst), .mem_read(mr[2]), .mem_write(mw[2]), .addr(ad[2]),
        .write_data(wd[2]), .read_data(rdd[2]), .ready(rdy[2]), .addr_err(err[2])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1 of an IDLE cycle; returns at posedge+1 of the following IDLE cycle.
    task automatic access(input int k, input bit rd, input bit wr, input logic [31:0] a,
                          input logic [31:0] d, input string tag, input bit scramble = 1'b0);
        exp_t   e;
        exp_t   got;
        int     stall = 0;
        bit     done  = 1'b0;
        bit     valid;
        longint key;

        valid = (a >= 32'd1024) && (a < 32'd1280) && (a[1:0] == 2'b00);
        key   = {32'(k), a};
        if (wr) begin
            if (valid) model[key] = d;
        end else begin
            last_rd[k] = valid ? model[key] : 32'h0;
        end
        e.tag = tag;
        e.rd  = last_rd[k];
        e.err = !valid || (rd && wr);
        sb.push_back(e);

        mr[k] = rd; mw[k] = wr; ad[k] = a; wd[k] = d;
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            if (rdy[k]) begin
                done = 1'b1;
            end else begin
                stall++;
                @(posedge clk); #1;
                if (scramble) begin
                    ad[k] = a ^ 32'h0000_0F0C;
                    wd[k] = ~d;
                end
            end
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_stall"}, 32'(stall), 32'(wc[k] + 1));
        got = sb.pop_front();
        chk({got.tag, "_rdata"}, rdd[k], got.rd);
        chk({got.tag, "_err"}, 32'(err[k]), 32'(got.err));
        mr[k] = 1'b0; mw[k] = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_bubble_ready"}, 32'(rdy[k]), 32'd1);
        chk({tag, "_rdata_hold"}, rdd[k], got.rd);
        chk({tag, "_err_clear"}, 32'(err[k]), 32'd0);
    endtask

    initial begin
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            mr[k] = 1'b0; mw[k] = 1'b0; ad[k] = '0; wd[k] = '0; last_rd[k] = '0;
        end
        @(posedge clk); @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            chk("reset_ready", 32'(rdy[k]), 32'd1);
            chk("reset_rdata", rdd[k], 32'h0);
            chk("reset_err", 32'(err[k]), 32'd0);
        end
        rst = 1'b1;
        @(posedge clk); #1;

        access(0, 1'b0, 1'b1, 32'd1024, 32'h1111_1111, "wr1024");
        access(0, 1'b1, 1'b0, 32'd1024, 32'h0, "rd1024");

        // Abort a write to 1024 with reset two cycles into WAIT
        mw[0] = 1'b1; ad[0] = 32'd1024; wd[0] = 32'hCAFE_F00D;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0; mw[0] = 1'b0;
        #1;
        chk("midrst_ready", 32'(rdy[0]), 32'd1);
        chk("midrst_rdata", rdd[0], 32'h0);
        chk("midrst_err", 32'(err[0]), 32'd0);
        for (int k = 0; k < 3; k++) last_rd[k] = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        access(0, 1'b1, 1'b0, 32'd1024, 32'h0, "rd1024_after_abort");

        access(0, 1'b0, 1'b1, 32'd1028, 32'hDEAD_BEEF, "wr1028");
        access(0, 1'b1, 1'b0, 32'd1028, 32'h0, "rd1028");

        access(0, 1'b0, 1'b1, 32'd1024, 32'hA000_0001, "b2b_wr1024");
        access(0, 1'b0, 1'b1, 32'd1028, 32'hB000_0002, "b2b_wr1028");
        access(0, 1'b0, 1'b1, 32'd1032, 32'hC000_0003, "b2b_wr1032");
        access(0, 1'b1, 1'b0, 32'd1024, 32'h0, "b2b_rd1024");
        access(0, 1'b1, 1'b0, 32'd1028, 32'h0, "b2b_rd1028");
        access(0, 1'b1, 1'b0, 32'd1032, 32'h0, "b2b_rd1032");

        access(0, 1'b0, 1'b1, 32'd1276, 32'h7E57_1276, "wr1276");
        access(0, 1'b1, 1'b0, 32'd1276, 32'h0, "rd1276");
        access(0, 1'b1, 1'b0, 32'd1280, 32'h0, "rd1280_oor");
        access(0, 1'b1, 1'b0, 32'd1028, 32'h0, "rd1028_reload");
        access(0, 1'b1, 1'b0, 32'd1020, 32'h0, "rd1020_oor");
        access(0, 1'b0, 1'b1, 32'd1026, 32'hFFFF_FFFF, "wr1026_misaligned");
        access(0, 1'b1, 1'b0, 32'd1024, 32'h0, "rd1024_post_misaligned");
        access(0, 1'b1, 1'b0, 32'd1028, 32'h0, "rd1028_post_misaligned");

        access(0, 1'b0, 1'b1, 32'd1040, 32'h1234_5678, "wr1040_scrambled", 1'b1);
        access(0, 1'b1, 1'b0, 32'd1040, 32'h0, "rd1040_scrambled", 1'b1);
        access(0, 1'b1, 1'b1, 32'd1044, 32'hABCD_0123, "rdwr_both");

        for (int k = 1; k < 3; k++) begin
            access(k, 1'b0, 1'b1, 32'd1100, 32'h5A5A_0000 + 32'(k), "sweep_wr1100");
            access(k, 1'b1, 1'b0, 32'd1100, 32'h0, "sweep_rd1100");
        end

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Multi-cycle data-memory responder on the far side of the MEM-stage memory port. It accepts word read/write requests (mem_read/mem_write, addr, write_data), returns read_data, and drives a ready handshake that the hazard/freeze logic uses to stall the pipeline during wait states. It replaces the single-cycle data memory with a configurable-latency SRAM model that has address translation and range checking.

## Interface
- REGISTER_LEN, 32, data and address width
- DEPTH, 64, number of 32-bit words stored
- BASE_ADDR, 1024, byte address of word 0
- WAIT_CYCLES, 4, wait states per access; legal range 1..15
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- mem_read  input  1  read request
- mem_write  input  1  write request
- addr  input  REGISTER_LEN  byte address, taken from the ALU result
- write_data  input  REGISTER_LEN  store data (Rm value)
- read_data  output  REGISTER_LEN  registered load data
- ready  output  1  high means the pipeline may advance; low means freeze
- addr_err  output  1  one-cycle pulse on completion of an out-of-range or malformed access

## Operation
- The block has three states: IDLE, WAIT and DONE. A 4-bit counter cnt runs in WAIT.
- A request (req) is mem_read | mem_write.
- **IDLE**
  - With no request, ready = 1 and the state stays IDLE.
  - With a request, ready = 0 combinationally in the same cycle. At the clock edge:
    - latch op, addr and write_data;
    - set cnt = 1;
    - go to WAIT.
- **WAIT**
  - ready = 0.
  - If cnt == WAIT_CYCLES, go to DONE and perform the access at that edge. Otherwise increment cnt.
- **DONE**
  - ready = 1 for exactly one cycle, then go to IDLE unconditionally.
  - During this cycle the requester advances. The next request is sampled in the following IDLE cycle.
- **Address translation**
  - index = (addr − BASE_ADDR) >> 2, using only the latched address.
  - The access is in range when BASE_ADDR ≤ addr < BASE_ADDR + 4·DEPTH.
  - addr[1:0] ≠ 0 is treated as out of range.
- **Write:** mem[index] ← latched write_data. read_data is unchanged.
- **Read:** read_data ← mem[index].
- **Out-of-range access**
  - A write is suppressed.
  - A read loads read_data ← 0.
  - addr_err = 1 during the DONE cycle.
- **Simultaneous mem_read and mem_write at accept**
  - The access is treated as a write.
  - addr_err = 1 during the DONE cycle.
- **Holding rule**
  - The requester holds its request stable while ready = 0.
  - The latched copy is authoritative, so input changes after accept are ignored.
  - Dropping req mid-access does not abort the access.
- read_data holds its value until the next read completes.
- The memory array is not reset; its contents are undefined until written.

## Timing
- Reset (rst = 0, asynchronous):
  - state = IDLE, cnt = 0;
  - read_data = 0, addr_err = 0;
  - ready = 1 whenever there is no request.
- Accept edge is at the end of cycle 0, where IDLE sees req. WAIT occupies cycles 1..WAIT_CYCLES. DONE occurs in cycle WAIT_CYCLES + 1.
- Total stall: WAIT_CYCLES + 1 cycles with ready = 0, followed by 1 cycle with ready = 1.
  - Default: request in cycle 0, ready low in cycles 0–4, ready high in cycle 5.
- The write commits at, and read_data updates on, the edge entering DONE. Both are visible throughout the DONE cycle.
- Back-to-back requests: DONE → IDLE → accept. Each access therefore costs WAIT_CYCLES + 2 cycles.
- Reset mid-access:
  - The state returns to IDLE immediately.
  - A write whose DONE-entry edge has not occurred is not committed.
  - read_data is cleared to 0.
- ready is combinational from state and req only. It has no path from addr or data.

## Test plan
- **Reset:** assert rst = 0 mid-WAIT of a write to 1024 → ready = 1, read_data = 0, addr_err = 0 immediately. A subsequent read of 1024 does not return that write's data.
- **Write then read, default latency:** write 0xDEADBEEF to 1028, then read 1028 → ready low for 5 cycles per access. read_data = 0xDEADBEEF in the read's DONE cycle, and it holds after.
- **Back-to-back stores to 1024, 1028, 1032 followed by three loads:**
  - each access has a 6-cycle period;
  - the loads return the correct words in order;
  - the IDLE bubble is visible between accesses.
- **Boundaries:**
  - read 1024 + 4·63 = 1276 → valid, addr_err = 0;
  - read 1280 → read_data = 0, addr_err pulses;
  - read 1020 → read_data = 0, addr_err pulses;
  - write 1026 (misaligned) → no memory change, addr_err pulses.
- **Protocol:** change addr and write_data during WAIT → the originally latched address and data are used. Assert mem_read and mem_write together → handled as a write, addr_err = 1 in DONE.
- **Parameter sweep:** WAIT_CYCLES = 1 gives ready low for 2 cycles. WAIT_CYCLES = 15 gives ready low for 16 cycles. Data is correct in both.
